// File: rtl/lut_table_writer_pkg.sv
// Shared types and constants for the LUT truth-table writer.
// FSM state encoding, header field positions and default geometry.
package lut_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  localparam int HDR_IDX_LSB = 0;
  localparam int HDR_IDX_MSB = 7;
  localparam int HDR_PAR_BIT = 15;

  localparam int DEF_IN_BITS = 6;
  localparam int DEF_WORD_W  = 16;

endpackage

// File: rtl/lut_table_writer_bank.sv
// Truth-table storage: NUM_NEURONS tables of 2**IN_BITS bits, one full-table
// write port and one registered single-bit read port.
module lut_table_bank
  import lut_writer_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int IN_BITS     = DEF_IN_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_NEURONS)-1:0] wr_idx,
  input  logic [(2**IN_BITS)-1:0]        wr_data,
  input  logic                           rd_en,
  input  logic [$clog2(NUM_NEURONS)-1:0] rd_idx,
  input  logic [IN_BITS-1:0]             rd_addr,
  output logic                           rd_data,
  output logic                           rd_valid
);

  localparam int DEPTH = 2**IN_BITS;

  logic [NUM_NEURONS-1:0][DEPTH-1:0] mem_q;
  logic                              rd_data_q, rd_data_d;
  logic                              rd_valid_q;
  logic                              in_range;

  assign in_range = (32'(rd_idx) < 32'(NUM_NEURONS));

  // Reads sample mem_q before a same-edge write lands, so a lookup racing a
  // commit sees the complete old table.
  always_comb begin
    rd_data_d = 1'b0;
    if (rd_en && in_range) begin
      rd_data_d = mem_q[rd_idx][rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q      <= '0;
      rd_data_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_idx] <= wr_data;
      end
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/lut_table_writer.sv
// Framed truth-table loader with atomic commit and concurrent 1-cycle lookups.
// Optional header parity check enabled by LUT_TABLE_WRITER_PARITY_EN.
module lut_table_writer
  import lut_writer_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int IN_BITS     = DEF_IN_BITS,
  parameter int WORD_W      = DEF_WORD_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [WORD_W-1:0]              cfg_data,
  input  logic                           cfg_last,
  input  logic                           lk_valid,
  input  logic [$clog2(NUM_NEURONS)-1:0] lk_neuron,
  input  logic [IN_BITS-1:0]             lk_addr,
  output logic                           lk_out,
  output logic                           lk_out_valid,
  output logic                           cfg_done,
  output logic                           cfg_err
);

  localparam int DEPTH  = 2**IN_BITS;
  localparam int WPT    = DEPTH / WORD_W;
  localparam int CNT_W  = (WPT > 1) ? $clog2(WPT) : 1;
  localparam int NIDX_W = $clog2(NUM_NEURONS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WPT - 1);

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [NIDX_W-1:0]              tgt_q, tgt_d;
  logic [WPT-1:0][WORD_W-1:0]     shadow_q, shadow_d;
  logic                           err_q, err_d;
  logic                           cfg_fire;
  logic                           hdr_ok;
  logic                           parity_ok;
  logic                           commit_en;
  logic [DEPTH-1:0]               shadow_flat;

  assign cfg_ready = rst_n && (state_q != ST_COMMIT);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign hdr_ok    = (32'(cfg_data[HDR_IDX_MSB:HDR_IDX_LSB]) < 32'(NUM_NEURONS));

`ifdef LUT_TABLE_WRITER_PARITY_EN
  logic par_q, par_d;
  logic hdr_par_q, hdr_par_d;

  always_comb begin
    par_d     = par_q;
    hdr_par_d = hdr_par_q;
    if (cfg_fire && state_q == ST_IDLE) begin
      par_d     = 1'b0;
      hdr_par_d = cfg_data[HDR_PAR_BIT];
    end else if (cfg_fire && state_q == ST_LOAD) begin
      par_d = par_q ^ (^cfg_data);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q     <= 1'b0;
      hdr_par_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      hdr_par_q <= hdr_par_d;
    end
  end

  // Final word is still on the bus, so fold it in before comparing.
  assign parity_ok = ((par_q ^ (^cfg_data)) == hdr_par_q);
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    shadow_d  = shadow_q;
    err_d     = 1'b0;
    commit_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_fire) begin
          if (hdr_ok && !cfg_last) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            tgt_d   = cfg_data[NIDX_W-1:0];
          end else if (cfg_last) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_LOAD: begin
        if (cfg_fire) begin
          shadow_d[cnt_q] = cfg_data;
          cnt_d           = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            if (!cfg_last) begin
              err_d   = 1'b1;
              state_d = ST_DRAIN;
            end else if (!parity_ok) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_COMMIT;
            end
          end else if (cfg_last) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_COMMIT: begin
        commit_en = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_DRAIN: begin
        if (cfg_fire && cfg_last) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tgt_q    <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  assign cfg_done    = (state_q == ST_COMMIT);
  assign cfg_err     = err_q;
  assign shadow_flat = shadow_q;

  lut_table_bank #(
    .NUM_NEURONS (NUM_NEURONS),
    .IN_BITS     (IN_BITS)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (commit_en),
    .wr_idx   (tgt_q),
    .wr_data  (shadow_flat),
    .rd_en    (lk_valid),
    .rd_idx   (lk_neuron),
    .rd_addr  (lk_addr),
    .rd_data  (lk_out),
    .rd_valid (lk_out_valid)
  );

endmodule
